// File: rtl/decode_ctrl_seq_pkg.sv
// Shared encodings for the ID-stage control unit: opcodes, control codes, FSM states, bundle type.
package decode_ctrl_seq_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    // Base ALU codes; M-extension ops occupy 5'b10xxx with funct3 in the low bits.
    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_PASSB  = 5'd10;
    localparam logic [1:0] ALU_M_BASE = 2'b10;

    localparam logic [3:0] IMM_NONE   = 4'd0;
    localparam logic [3:0] IMM_I      = 4'd1;
    localparam logic [3:0] IMM_S      = 4'd2;
    localparam logic [3:0] IMM_B      = 4'd3;
    localparam logic [3:0] IMM_U      = 4'd4;
    localparam logic [3:0] IMM_J      = 4'd5;

    localparam logic [1:0] WB_ALU     = 2'd0;
    localparam logic [1:0] WB_MEM     = 2'd1;
    localparam logic [1:0] WB_PC4     = 2'd2;
    localparam logic [1:0] WB_MDU     = 2'd3;

    localparam logic [2:0] BR_NONE    = 3'd0;
    localparam logic [2:0] BR_EQ      = 3'd1;
    localparam logic [2:0] BR_NE      = 3'd2;
    localparam logic [2:0] BR_LT      = 3'd3;
    localparam logic [2:0] BR_GE      = 3'd4;
    localparam logic [2:0] BR_LTU     = 3'd5;
    localparam logic [2:0] BR_GEU     = 3'd6;
    localparam logic [2:0] BR_JUMP    = 3'd7;

    // Loads encode as {1, funct3}, stores as {1, funct3[1:0]}, so any access is non-zero.
    localparam logic       MEM_EN     = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    typedef struct packed {
        logic       regWriteEn;
        logic       data1AluSel;
        logic       data2AluSel;
        logic [2:0] memWrite;
        logic [3:0] memRead;
        logic [2:0] branchJump;
        logic [3:0] immSel;
        logic [1:0] wbSel;
    } ctrl_t;

    // Integer ALU op shared by R and I forms; alt selects SUB/SRA.
    function automatic logic [4:0] aluBaseOp(input logic [2:0] funct3, input logic alt);
        logic [4:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Conditional branch kind from funct3; reserved encodings decode as no branch.
    function automatic logic [2:0] branchCode(input logic [2:0] funct3);
        logic [2:0] code;
        case (funct3)
            3'b000:  code = BR_EQ;
            3'b001:  code = BR_NE;
            3'b100:  code = BR_LT;
            3'b101:  code = BR_GE;
            3'b110:  code = BR_LTU;
            3'b111:  code = BR_GEU;
            default: code = BR_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/decode_ctrl_seq_if.sv
// Handshake and control-bundle bus between IF/ID, the decode unit and the ID/EX boundary.
interface decode_ctrl_seq_if #(
    parameter int ALU_OP_W = 5
);
    logic                in_valid;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                stall_in;
    logic                flush;

    logic [ALU_OP_W-1:0] alu_op;
    logic                reg_write_en;
    logic                data1_alu_sel;
    logic                data2_alu_sel;
    logic [2:0]          mem_write;
    logic [3:0]          mem_read;
    logic [2:0]          branch_jump;
    logic [3:0]          imm_sel;
    logic [1:0]          wb_sel;
    logic                out_valid;
    logic                stall_req;
    logic                illegal_instr;

    modport master (
        output in_valid, opcode, funct3, funct7, stall_in, flush,
        input  alu_op, reg_write_en, data1_alu_sel, data2_alu_sel, mem_write,
               mem_read, branch_jump, imm_sel, wb_sel, out_valid, stall_req, illegal_instr
    );

    modport slave (
        input  in_valid, opcode, funct3, funct7, stall_in, flush,
        output alu_op, reg_write_en, data1_alu_sel, data2_alu_sel, mem_write,
               mem_read, branch_jump, imm_sel, wb_sel, out_valid, stall_req, illegal_instr
    );
endinterface

// File: rtl/decode_ctrl_seq_decode_comb.sv
// Purely combinational RV32IM field decoder: control bundle plus M-class and illegal flags.
module decode_comb
    import decode_ctrl_seq_pkg::*;
#(
    parameter int ALU_OP_W = 5
) (
    input  logic [6:0]          i_opcode,
    input  logic [2:0]          i_funct3,
    input  logic [6:0]          i_funct7,
    output ctrl_t               o_ctrl,
    output logic [ALU_OP_W-1:0] o_aluOp,
    output logic                o_isMul,
    output logic                o_isDiv,
    output logic                o_illegal
);

    logic w_isMop;

    assign w_isMop = (i_funct7 == F7_MULDIV);

    // Map opcode class and function fields onto the control bundle; unknown opcodes flag illegal.
    always_comb begin
        o_ctrl    = '0;
        o_aluOp   = '0;
        o_isMul   = 1'b0;
        o_isDiv   = 1'b0;
        o_illegal = 1'b0;
        case (i_opcode)
            OPC_R: begin
                o_ctrl.regWriteEn = 1'b1;
                if (w_isMop) begin
                    o_aluOp       = ALU_OP_W'({ALU_M_BASE, i_funct3});
                    o_ctrl.wbSel  = WB_MDU;
                    o_isDiv       = i_funct3[2];
                    o_isMul       = ~i_funct3[2];
                end else begin
                    o_aluOp       = ALU_OP_W'(aluBaseOp(i_funct3, i_funct7[5]));
                    o_ctrl.wbSel  = WB_ALU;
                end
            end
            OPC_I: begin
                o_ctrl.regWriteEn  = 1'b1;
                o_ctrl.data2AluSel = 1'b1;
                o_ctrl.immSel      = IMM_I;
                o_aluOp            = ALU_OP_W'(aluBaseOp(i_funct3, (i_funct3 == 3'b101) && i_funct7[5]));
            end
            OPC_LOAD: begin
                o_ctrl.regWriteEn  = 1'b1;
                o_ctrl.data2AluSel = 1'b1;
                o_ctrl.immSel      = IMM_I;
                o_ctrl.wbSel       = WB_MEM;
                o_ctrl.memRead     = {MEM_EN, i_funct3};
                o_aluOp            = ALU_OP_W'(ALU_ADD);
            end
            OPC_STORE: begin
                o_ctrl.data2AluSel = 1'b1;
                o_ctrl.immSel      = IMM_S;
                o_ctrl.memWrite    = {MEM_EN, i_funct3[1:0]};
                o_aluOp            = ALU_OP_W'(ALU_ADD);
            end
            OPC_BRANCH: begin
                o_ctrl.data1AluSel = 1'b1;
                o_ctrl.data2AluSel = 1'b1;
                o_ctrl.immSel      = IMM_B;
                o_ctrl.branchJump  = branchCode(i_funct3);
                o_aluOp            = ALU_OP_W'(ALU_ADD);
            end
            OPC_JAL: begin
                o_ctrl.regWriteEn  = 1'b1;
                o_ctrl.data1AluSel = 1'b1;
                o_ctrl.data2AluSel = 1'b1;
                o_ctrl.immSel      = IMM_J;
                o_ctrl.branchJump  = BR_JUMP;
                o_ctrl.wbSel       = WB_PC4;
                o_aluOp            = ALU_OP_W'(ALU_ADD);
            end
            OPC_JALR: begin
                o_ctrl.regWriteEn  = 1'b1;
                o_ctrl.data2AluSel = 1'b1;
                o_ctrl.immSel      = IMM_I;
                o_ctrl.branchJump  = BR_JUMP;
                o_ctrl.wbSel       = WB_PC4;
                o_aluOp            = ALU_OP_W'(ALU_ADD);
            end
            OPC_LUI: begin
                o_ctrl.regWriteEn  = 1'b1;
                o_ctrl.data2AluSel = 1'b1;
                o_ctrl.immSel      = IMM_U;
                o_aluOp            = ALU_OP_W'(ALU_PASSB);
            end
            OPC_AUIPC: begin
                o_ctrl.regWriteEn  = 1'b1;
                o_ctrl.data1AluSel = 1'b1;
                o_ctrl.data2AluSel = 1'b1;
                o_ctrl.immSel      = IMM_U;
                o_aluOp            = ALU_OP_W'(ALU_ADD);
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_ctrl_seq.sv
// ID-stage control unit: registers the decoded bundle into ID/EX and sequences multi-cycle MUL/DIV.
module decode_ctrl_seq
    import decode_ctrl_seq_pkg::*;
#(
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 32,
    parameter int ALU_OP_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    decode_ctrl_seq_if.slave bus
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_WAIT = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_WAIT = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit MUL_MULTI = (MUL_CYCLES > 1);
    localparam bit DIV_MULTI = (DIV_CYCLES > 1);

    ctrl_t               w_ctrl;
    logic [ALU_OP_W-1:0] w_aluOp;
    logic                w_isMul;
    logic                w_isDiv;
    logic                w_illegal;
    logic                w_multiCycle;
    logic [CNT_W-1:0]    w_waitInit;

    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    ctrl_t               r_ctrl;
    logic [ALU_OP_W-1:0] r_aluOp;
    logic                r_valid;
    logic                r_illegal;
    ctrl_t               r_savedCtrl;
    logic [ALU_OP_W-1:0] r_savedAluOp;

    decode_comb #(
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .i_opcode  (bus.opcode),
        .i_funct3  (bus.funct3),
        .i_funct7  (bus.funct7),
        .o_ctrl    (w_ctrl),
        .o_aluOp   (w_aluOp),
        .o_isMul   (w_isMul),
        .o_isDiv   (w_isDiv),
        .o_illegal (w_illegal)
    );

    assign w_multiCycle = (w_isMul && MUL_MULTI) || (w_isDiv && DIV_MULTI);
    assign w_waitInit   = w_isDiv ? DIV_WAIT : MUL_WAIT;

    // Sequencer: reset > flush > stall_in > normal; the edge that brings cnt to 0 releases the held M-op.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_ctrl       <= '0;
            r_aluOp      <= '0;
            r_valid      <= 1'b0;
            r_illegal    <= 1'b0;
            r_savedCtrl  <= '0;
            r_savedAluOp <= '0;
        end else if (bus.flush) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ctrl    <= '0;
            r_aluOp   <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!bus.stall_in) begin
                        r_ctrl    <= '0;
                        r_aluOp   <= '0;
                        r_valid   <= 1'b0;
                        r_illegal <= 1'b0;
                        if (bus.in_valid) begin
                            if (w_illegal) begin
                                r_illegal <= 1'b1;
                            end else if (w_multiCycle) begin
                                r_state      <= ST_WAIT;
                                r_cnt        <= w_waitInit;
                                r_savedCtrl  <= w_ctrl;
                                r_savedAluOp <= w_aluOp;
                            end else begin
                                r_ctrl  <= w_ctrl;
                                r_aluOp <= w_aluOp;
                                r_valid <= 1'b1;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt > CNT_ONE) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end else begin
                        r_cnt <= '0;
                        if (!bus.stall_in) begin
                            r_ctrl  <= r_savedCtrl;
                            r_aluOp <= r_savedAluOp;
                            r_valid <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.alu_op        = r_aluOp;
    assign bus.reg_write_en  = r_ctrl.regWriteEn;
    assign bus.data1_alu_sel = r_ctrl.data1AluSel;
    assign bus.data2_alu_sel = r_ctrl.data2AluSel;
    assign bus.mem_write     = r_ctrl.memWrite;
    assign bus.mem_read      = r_ctrl.memRead;
    assign bus.branch_jump   = r_ctrl.branchJump;
    assign bus.imm_sel       = r_ctrl.immSel;
    assign bus.wb_sel        = r_ctrl.wbSel;
    assign bus.out_valid     = r_valid;
    assign bus.illegal_instr = r_illegal;
    assign bus.stall_req     = (r_state == ST_WAIT);

endmodule

// File: tb/tb_decode_ctrl_seq.sv
// Self-checking bench for decode_ctrl_seq: directed scenarios then random traffic against a cycle model.
module tb_decode_ctrl_seq;

    localparam int MUL_L = 1;
    localparam int DIV_L = 4;
    localparam int AW    = 5;

    typedef struct packed {
        logic [4:0] alu;
        logic       rw;
        logic       d1;
        logic       d2;
        logic [2:0] mw;
        logic [3:0] mr;
        logic [2:0] bj;
        logic [3:0] imm;
        logic [1:0] wb;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    int   checks   = 0;
    int   failures = 0;

    exp_t cur;
    exp_t pend;
    bit   curValid;
    bit   curIll;
    bit   mWaiting;
    int   releaseCycle;
    int   cycle = 0;

    int   stallCycles;
    int   k;
    int   idx;
    logic [6:0] rOp;
    logic [6:0] rF7;
    logic [6:0] opTab [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

    decode_ctrl_seq_if #(.ALU_OP_W(AW)) bus ();

    decode_ctrl_seq #(
        .MUL_CYCLES (MUL_L),
        .DIV_CYCLES (DIV_L),
        .ALU_OP_W   (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 time-unit clock.
    always #5 clk = ~clk;

    // Expected bundle straight from the RV32IM decode rules, with table lookups by funct3.
    function automatic void refDecode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                      output exp_t e, output bit ill, output int lat);
        int aluTab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int brTab  [8] = '{1, 2, 0, 0, 3, 4, 5, 6};
        bit alt = f7[5];
        e   = '0;
        ill = 1'b0;
        lat = 1;
        case (op)
            7'h33: begin
                e.rw = 1'b1;
                if (f7 == 7'h01) begin
                    e.alu = 5'(16 + int'(f3));
                    e.wb  = 2'd3;
                    lat   = f3[2] ? DIV_L : MUL_L;
                end else begin
                    e.alu = 5'(aluTab[f3] + (((f3 == 3'd0 || f3 == 3'd5) && alt) ? 1 : 0));
                end
            end
            7'h13: begin
                e.rw = 1'b1; e.d2 = 1'b1; e.imm = 4'd1;
                e.alu = 5'(aluTab[f3] + ((f3 == 3'd5 && alt) ? 1 : 0));
            end
            7'h03: begin
                e.rw = 1'b1; e.d2 = 1'b1; e.imm = 4'd1; e.wb = 2'd1;
                e.mr = 4'(8 + int'(f3));
            end
            7'h23: begin
                e.d2 = 1'b1; e.imm = 4'd2;
                e.mw = 3'(4 + int'(f3[1:0]));
            end
            7'h63: begin
                e.d1 = 1'b1; e.d2 = 1'b1; e.imm = 4'd3;
                e.bj = 3'(brTab[f3]);
            end
            7'h6F: begin
                e.rw = 1'b1; e.d1 = 1'b1; e.d2 = 1'b1; e.imm = 4'd5; e.bj = 3'd7; e.wb = 2'd2;
            end
            7'h67: begin
                e.rw = 1'b1; e.d2 = 1'b1; e.imm = 4'd1; e.bj = 3'd7; e.wb = 2'd2;
            end
            7'h37: begin
                e.rw = 1'b1; e.d2 = 1'b1; e.imm = 4'd4; e.alu = 5'd10;
            end
            7'h17: begin
                e.rw = 1'b1; e.d1 = 1'b1; e.d2 = 1'b1; e.imm = 4'd4;
            end
            default: ill = 1'b1;
        endcase
    endfunction

    // Advance the expected outputs by one clock edge; an M-op is released at a target cycle that stalls push out.
    task automatic modelEdge(input bit rst, input bit iv, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input bit st, input bit fl);
        exp_t e;
        bit   ill;
        int   lat;
        cycle++;
        if (rst || fl) begin
            cur = '0; curValid = 1'b0; curIll = 1'b0; mWaiting = 1'b0;
        end else if (mWaiting) begin
            if (cycle >= releaseCycle) begin
                if (st) releaseCycle = cycle + 1;
                else begin
                    cur = pend; curValid = 1'b1; mWaiting = 1'b0;
                end
            end
        end else if (!st) begin
            cur = '0; curValid = 1'b0; curIll = 1'b0;
            if (iv) begin
                refDecode(op, f3, f7, e, ill, lat);
                if (ill) curIll = 1'b1;
                else if (lat > 1) begin
                    mWaiting = 1'b1; pend = e; releaseCycle = cycle + lat - 1;
                end else begin
                    cur = e; curValid = 1'b1;
                end
            end
        end
    endtask

    // Compare every DUT output against the model.
    task automatic checkOutput(input string tag);
        exp_t got;
        got = {bus.alu_op, bus.reg_write_en, bus.data1_alu_sel, bus.data2_alu_sel, bus.mem_write,
               bus.mem_read, bus.branch_jump, bus.imm_sel, bus.wb_sel};
        checks++;
        assert (got === cur) else begin
            failures++;
            $error("[TB] FAIL %s bundle got=%h exp=%h", tag, got, cur);
        end
        checks++;
        assert (bus.out_valid === curValid) else begin
            failures++;
            $error("[TB] FAIL %s out_valid got=%b exp=%b", tag, bus.out_valid, curValid);
        end
        checks++;
        assert (bus.illegal_instr === curIll) else begin
            failures++;
            $error("[TB] FAIL %s illegal_instr got=%b exp=%b", tag, bus.illegal_instr, curIll);
        end
        checks++;
        assert (bus.stall_req === mWaiting) else begin
            failures++;
            $error("[TB] FAIL %s stall_req got=%b exp=%b", tag, bus.stall_req, mWaiting);
        end
    endtask

    // Targeted comparison of one value against a fixed expectation.
    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, step the clock and the model, then check #1 after the edge.
    task automatic applyStimulus(input string tag, input bit rst, input bit iv, input logic [6:0] op,
                                 input logic [2:0] f3, input logic [6:0] f7, input bit st, input bit fl);
        reset        = rst;
        bus.in_valid = iv;
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.stall_in = st;
        bus.flush    = fl;
        @(posedge clk);
        modelEdge(rst, iv, op, f3, f7, st, fl);
        #1;
        checkOutput(tag);
    endtask

    // Directed scenarios followed by random traffic, then the summary line.
    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0;
        bus.stall_in = 1'b0; bus.flush = 1'b0;
        cur = '0; pend = '0; curValid = 1'b0; curIll = 1'b0; mWaiting = 1'b0; releaseCycle = 0;

        applyStimulus("reset0", 1, 0, 7'h00, 3'd0, 7'h00, 0, 0);
        applyStimulus("reset1", 1, 0, 7'h00, 3'd0, 7'h00, 0, 0);

        $display("[TB] ADD decode");
        applyStimulus("add", 0, 1, 7'h33, 3'd0, 7'h00, 0, 0);
        checkValue("add_rw", 32'(bus.reg_write_en), 32'd1);
        checkValue("add_mem", 32'({bus.mem_write, bus.mem_read}), 32'd0);
        applyStimulus("idle", 0, 0, 7'h00, 3'd0, 7'h00, 0, 0);

        $display("[TB] DIV latency");
        applyStimulus("div_issue", 0, 1, 7'h33, 3'b100, 7'h01, 0, 0);
        stallCycles = int'(bus.stall_req);
        k = 0;
        while (!bus.out_valid && k < 20) begin
            applyStimulus("div_wait", 0, 0, 7'h00, 3'd0, 7'h00, 0, 0);
            stallCycles += int'(bus.stall_req);
            k++;
        end
        checkValue("div_released", 32'(bus.out_valid), 32'd1);
        checkValue("div_stall_cycles", 32'(stallCycles), 32'(DIV_L - 1));
        checkValue("div_alu_op", 32'(bus.alu_op), 32'd20);

        $display("[TB] DIV with stall at release");
        applyStimulus("divs_issue", 0, 1, 7'h33, 3'b100, 7'h01, 0, 0);
        k = 1;
        while (!bus.out_valid && k < 20) begin
            applyStimulus("divs_wait", 0, 0, 7'h00, 3'd0, 7'h00, (k == 3 || k == 4), 0);
            k++;
        end
        checkValue("divs_delay", 32'(k - 1), 32'(DIV_L - 1 + 2));

        $display("[TB] DIV flushed at cnt 2");
        applyStimulus("divf_issue", 0, 1, 7'h33, 3'b110, 7'h01, 0, 0);
        applyStimulus("divf_wait", 0, 0, 7'h00, 3'd0, 7'h00, 0, 0);
        applyStimulus("divf_flush", 0, 0, 7'h00, 3'd0, 7'h00, 0, 1);
        checkValue("divf_stall_req", 32'(bus.stall_req), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus("divf_after", 0, 0, 7'h00, 3'd0, 7'h00, 0, 0);

        $display("[TB] LW held by stall, then BEQ");
        applyStimulus("lw", 0, 1, 7'h03, 3'b010, 7'h00, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus("lw_hold", 0, 1, 7'h63, 3'b000, 7'h00, 1, 0);
        checkValue("lw_mem_read", 32'(bus.mem_read), 32'hA);
        applyStimulus("beq", 0, 1, 7'h63, 3'b000, 7'h00, 0, 0);
        checkValue("beq_branch", 32'(bus.branch_jump), 32'd1);

        $display("[TB] illegal opcode");
        applyStimulus("illegal", 0, 1, 7'h7F, 3'd0, 7'h00, 0, 0);
        applyStimulus("illegal_after", 0, 0, 7'h00, 3'd0, 7'h00, 0, 0);

        $display("[TB] MUL single cycle, flush beats stall");
        applyStimulus("mul", 0, 1, 7'h33, 3'b001, 7'h01, 0, 0);
        applyStimulus("flush_stall", 0, 1, 7'h37, 3'd0, 7'h00, 1, 1);

        $display("[TB] reset during WAIT");
        applyStimulus("divr_issue", 0, 1, 7'h33, 3'b111, 7'h01, 0, 0);
        applyStimulus("divr_wait", 0, 0, 7'h00, 3'd0, 7'h00, 0, 0);
        applyStimulus("divr_reset", 1, 0, 7'h00, 3'd0, 7'h00, 0, 0);
        checkValue("divr_stall_req", 32'(bus.stall_req), 32'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            idx = int'($urandom_range(0, 13));
            if (idx > 9) idx = 0;
            rOp = ($urandom_range(0, 24) == 0) ? 7'($urandom) : opTab[idx];
            case ($urandom_range(0, 3))
                0:       rF7 = 7'h00;
                1:       rF7 = 7'h20;
                2:       rF7 = 7'h01;
                default: rF7 = 7'($urandom);
            endcase
            applyStimulus("random", ($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0), rOp,
                          3'($urandom), rF7, ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
